// File: rtl/td4x_pkg.sv
// Shared types and constants for the TD4X controller slice: opcodes,
// datapath source-select encoding, controller states and the positions
// of the output-port and PC bits inside the active-low load vector.
package td4x_pkg;

   typedef enum logic [3:0] {
      OP_ADD     = 4'b0000,
      OP_MOV_RS  = 4'b0001,
      OP_IN      = 4'b0010,
      OP_MOV_IMM = 4'b0011,
      OP_OUT_RD  = 4'b1001,
      OP_OUT_IMM = 4'b1011,
      OP_JZ      = 4'b1100,
      OP_HALT    = 4'b1101,
      OP_JNC     = 4'b1110,
      OP_JMP     = 4'b1111
   } opcode_e;

   typedef enum logic [1:0] {
      SEL_REG  = 2'b00,
      SEL_RSVD = 2'b01,
      SEL_IN   = 2'b10,
      SEL_ZERO = 2'b11
   } sel_e;

   typedef enum logic [1:0] {
      ST_FETCH,
      ST_EXEC,
      ST_WAIT_IN,
      ST_HALT
   } state_e;

   // Register index width; a two-register file still needs one index bit.
   function automatic int reg_idx_width(input int nreg);
      return (nreg > 2) ? $clog2(nreg) : 1;
   endfunction

   // The output-port load sits just above the register loads.
   function automatic int ld_out_idx(input int nreg);
      return nreg;
   endfunction

   // The PC load is the topmost bit of the load vector.
   function automatic int ld_pc_idx(input int nreg);
      return nreg + 1;
   endfunction

endpackage

// File: rtl/td4x_op_decode.sv
// Combinational decode for the TD4X controller: turns the current state,
// the held instruction and the flags into the datapath select, the
// register read index, the active-low load strobes and the next-step hints.
module td4x_op_decode
   import td4x_pkg::*;
#(
   parameter int NREG = 2,
   parameter int RW   = reg_idx_width(NREG)
)(
   input  state_e          state,
   input  opcode_e         op,
   input  logic [RW-1:0]   rd,
   input  logic [RW-1:0]   rs,
   input  logic            c_flag,
   input  logic            z_flag,
   input  logic            in_valid,
   output logic [1:0]      sel,
   output logic [RW-1:0]   src_reg,
   output logic [NREG+1:0] ld_n,
   output logic            in_ready,
   output logic            go_wait,
   output logic            go_halt
);

   localparam int LD_OUT = ld_out_idx(NREG);
   localparam int LD_PC  = ld_pc_idx(NREG);

   logic [NREG+1:0] rd_load_n;

   // Low mask for the destination register; an index past the file loads nothing.
   always_comb begin
      rd_load_n = '1;
      for (int i = 0; i < NREG; i++) begin
         if (rd == RW'(i)) begin
            rd_load_n[i] = 1'b0;
         end
      end
   end

   // Per-state, per-opcode selection of source, destination and handshake.
   always_comb begin
      sel      = SEL_ZERO;
      src_reg  = '0;
      ld_n     = '1;
      in_ready = 1'b0;
      go_wait  = 1'b0;
      go_halt  = 1'b0;
      case (state)
         ST_EXEC: begin
            case (op)
               OP_ADD: begin
                  sel     = SEL_REG;
                  src_reg = rd;
                  ld_n    = rd_load_n;
               end
               OP_MOV_IMM: begin
                  ld_n = rd_load_n;
               end
               OP_MOV_RS: begin
                  sel     = SEL_REG;
                  src_reg = rs;
                  ld_n    = rd_load_n;
               end
               OP_IN: begin
                  sel      = SEL_IN;
                  in_ready = 1'b1;
                  if (in_valid) begin
                     ld_n = rd_load_n;
                  end else begin
                     go_wait = 1'b1;
                  end
               end
               OP_OUT_IMM: begin
                  ld_n[LD_OUT] = 1'b0;
               end
               OP_OUT_RD: begin
                  sel          = SEL_REG;
                  src_reg      = rd;
                  ld_n[LD_OUT] = 1'b0;
               end
               OP_JMP: begin
                  ld_n[LD_PC] = 1'b0;
               end
               OP_JNC: begin
                  ld_n[LD_PC] = c_flag;
               end
               OP_JZ: begin
                  ld_n[LD_PC] = ~z_flag;
               end
               OP_HALT: begin
                  go_halt = 1'b1;
               end
               default: begin
               end
            endcase
         end
         ST_WAIT_IN: begin
            sel      = SEL_IN;
            in_ready = 1'b1;
            if (in_valid) begin
               ld_n = rd_load_n;
            end
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/td4x_ctrl.sv
// TD4X control unit: fetches one instruction into IR, executes it in a
// single cycle (or stalls on the input port for IN), keeps the carry and
// zero flags, and parks in HALT until reset.
module td4x_ctrl
   import td4x_pkg::*;
#(
   parameter  int DW   = 4,
   parameter  int NREG = 2,
   localparam int RW   = reg_idx_width(NREG),
   localparam int IW   = 4 + RW + DW
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [IW-1:0]   instr,
   input  logic            instr_valid,
   output logic            instr_ready,
   input  logic            alu_c,
   input  logic            alu_z,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [1:0]      sel,
   output logic [RW-1:0]   src_reg,
   output logic [DW-1:0]   imm,
   output logic [NREG+1:0] ld_n,
   output logic            c_flag,
   output logic            z_flag,
   output logic            halted
);

   state_e        state;
   logic [IW-1:0] ir;
   opcode_e       ir_op;
   logic [RW-1:0] ir_rd;
   logic [RW-1:0] ir_rs;
   logic          go_wait;
   logic          go_halt;
   logic          reg_load;

   assign ir_op = opcode_e'(ir[IW-1 -: 4]);
   assign ir_rd = ir[DW +: RW];
   assign ir_rs = ir[RW-1:0];
   assign imm   = ir[DW-1:0];

   // Flags follow the adder only when a general register is being written.
   assign reg_load    = ~&ld_n[NREG-1:0];
   assign instr_ready = rst_n && (state == ST_FETCH);
   assign halted      = (state == ST_HALT);

   td4x_op_decode #(
      .NREG (NREG),
      .RW   (RW)
   ) u_decode (
      .state    (state),
      .op       (ir_op),
      .rd       (ir_rd),
      .rs       (ir_rs),
      .c_flag   (c_flag),
      .z_flag   (z_flag),
      .in_valid (in_valid),
      .sel      (sel),
      .src_reg  (src_reg),
      .ld_n     (ld_n),
      .in_ready (in_ready),
      .go_wait  (go_wait),
      .go_halt  (go_halt)
   );

   // Sequencer, instruction register and flags; reset drops any pending load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_FETCH;
         ir     <= '0;
         c_flag <= 1'b0;
         z_flag <= 1'b0;
      end else begin
         if (reg_load) begin
            c_flag <= alu_c;
            z_flag <= alu_z;
         end
         case (state)
            ST_FETCH: begin
               if (instr_valid) begin
                  ir    <= instr;
                  state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (go_halt) begin
                  state <= ST_HALT;
               end else if (go_wait) begin
                  state <= ST_WAIT_IN;
               end else begin
                  state <= ST_FETCH;
               end
            end
            ST_WAIT_IN: begin
               if (in_valid) begin
                  state <= ST_FETCH;
               end
            end
            ST_HALT: begin
               state <= ST_HALT;
            end
            default: begin
               state <= ST_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_td4x_ctrl.sv
// Testbench for td4x_ctrl (DW=4, NREG=2): directed scenarios with
// hand-computed expectations plus a randomized run, all cross-checked
// every cycle against an instruction-level model of the controller.
module tb_td4x_ctrl;

   localparam int DW   = 4;
   localparam int NREG = 2;
   localparam int RW   = 1;
   localparam int IW   = 4 + RW + DW;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [IW-1:0]   instr;
   logic            instr_valid;
   logic            instr_ready;
   logic            alu_c;
   logic            alu_z;
   logic            in_valid;
   logic            in_ready;
   logic [1:0]      sel;
   logic [RW-1:0]   src_reg;
   logic [DW-1:0]   imm;
   logic [NREG+1:0] ld_n;
   logic            c_flag;
   logic            z_flag;
   logic            halted;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   td4x_ctrl #(
      .DW   (DW),
      .NREG (NREG)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .alu_c       (alu_c),
      .alu_z       (alu_z),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .sel         (sel),
      .src_reg     (src_reg),
      .imm         (imm),
      .ld_n        (ld_n),
      .c_flag      (c_flag),
      .z_flag      (z_flag),
      .halted      (halted)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle of inputs just after the rising edge, then settle to the falling edge.
   task automatic applyStimulus(input logic r, input logic [IW-1:0] ins, input logic iv,
                                input logic inv, input logic c, input logic z);
      @(posedge clk);
      #1;
      rst_n       = r;
      instr       = ins;
      instr_valid = iv;
      in_valid    = inv;
      alu_c       = c;
      alu_z       = z;
      @(negedge clk);
   endtask

   // Instruction semantics: where the result goes and where the adder operand comes from.
   typedef enum {D_NONE, D_REG, D_OUT, D_PC} dest_e;
   typedef enum {S_ZERO, S_RD, S_RS, S_PORT} srck_e;

   function automatic dest_e dest_of(input logic [3:0] op, input logic c, input logic z);
      case (op)
         4'b0000, 4'b0001, 4'b0010, 4'b0011: return D_REG;
         4'b1001, 4'b1011:                   return D_OUT;
         4'b1111:                            return D_PC;
         4'b1110:                            return c ? D_NONE : D_PC;
         4'b1100:                            return z ? D_PC : D_NONE;
         default:                            return D_NONE;
      endcase
   endfunction

   function automatic srck_e src_of(input logic [3:0] op);
      case (op)
         4'b0000, 4'b1001: return S_RD;
         4'b0001:          return S_RS;
         4'b0010:          return S_PORT;
         default:          return S_ZERO;
      endcase
   endfunction

   localparam int PH_IDLE    = 0;
   localparam int PH_RUN     = 1;
   localparam int PH_BLOCKED = 2;
   localparam int PH_STOPPED = 3;

   int            m_phase = PH_IDLE;
   logic [3:0]    m_op    = '0;
   int            m_rd    = 0;
   logic [DW-1:0] m_imm   = '0;
   logic          m_c     = 1'b0;
   logic          m_z     = 1'b0;

   // Per-cycle comparison of every output against the instruction-level model.
   always @(negedge clk) begin
      logic [NREG+1:0] e_ld;
      logic [1:0]      e_sel;
      int              e_src;
      logic            e_ir, e_halt, e_inr;
      bit              chk_src, loads;
      dest_e           d;
      srck_e           s;
      e_ld = '1; e_sel = 2'b11; e_src = 0; e_ir = 1'b1; e_halt = 1'b0; e_inr = 1'b0;
      chk_src = 1'b1; loads = 1'b0; d = D_NONE; s = S_ZERO;
      if (!rst_n) begin
         m_phase = PH_IDLE; m_c = 1'b0; m_z = 1'b0; m_imm = '0; m_op = '0; m_rd = 0;
         e_ir = 1'b0;
      end else if (m_phase == PH_STOPPED) begin
         e_ir = 1'b0; e_halt = 1'b1;
      end else if (m_phase == PH_RUN || m_phase == PH_BLOCKED) begin
         e_ir = 1'b0;
         d = dest_of(m_op, m_c, m_z);
         s = src_of(m_op);
         if (s == S_PORT) begin
            e_inr = 1'b1;
            loads = in_valid;
         end else begin
            loads = (d != D_NONE);
         end
         case (s)
            S_RD:    begin e_sel = 2'b00; e_src = m_rd; end
            S_RS:    begin e_sel = 2'b00; e_src = int'(m_imm[RW-1:0]); end
            S_PORT:  begin e_sel = 2'b10; chk_src = 1'b0; end
            default: begin e_sel = 2'b11; chk_src = 1'b0; end
         endcase
         if (loads) begin
            case (d)
               D_REG:   e_ld[m_rd] = 1'b0;
               D_OUT:   e_ld[NREG] = 1'b0;
               D_PC:    e_ld[NREG+1] = 1'b0;
               default: e_ld = '1;
            endcase
         end
      end
      checkOutput("instr_ready", instr_ready, e_ir);
      checkOutput("halted", halted, e_halt);
      checkOutput("sel", sel, e_sel);
      checkOutput("ld_n", ld_n, e_ld);
      checkOutput("in_ready", in_ready, e_inr);
      checkOutput("c_flag", c_flag, m_c);
      checkOutput("z_flag", z_flag, m_z);
      checkOutput("imm", imm, m_imm);
      if (chk_src) checkOutput("src_reg", src_reg, e_src);
      if (rst_n) begin
         if (loads && d == D_REG) begin
            m_c = alu_c;
            m_z = alu_z;
         end
         case (m_phase)
            PH_IDLE: begin
               if (instr_valid) begin
                  m_op    = instr[IW-1 -: 4];
                  m_rd    = int'(instr[DW +: RW]);
                  m_imm   = instr[DW-1:0];
                  m_phase = PH_RUN;
               end
            end
            PH_RUN: begin
               if (m_op == 4'b1101)                   m_phase = PH_STOPPED;
               else if (m_op == 4'b0010 && !in_valid) m_phase = PH_BLOCKED;
               else                                   m_phase = PH_IDLE;
            end
            PH_BLOCKED: begin
               if (in_valid) m_phase = PH_IDLE;
            end
            default: m_phase = PH_STOPPED;
         endcase
      end
   end

   localparam logic [IW-1:0] I_MOV1_5 = 9'b0011_1_0101;
   localparam logic [IW-1:0] I_ADD0_F = 9'b0000_0_1111;
   localparam logic [IW-1:0] I_ADD1_1 = 9'b0000_1_0001;
   localparam logic [IW-1:0] I_JNC_3  = 9'b1110_0_0011;
   localparam logic [IW-1:0] I_JNC_2  = 9'b1110_0_0010;
   localparam logic [IW-1:0] I_JZ_A   = 9'b1100_0_1010;
   localparam logic [IW-1:0] I_IN1    = 9'b0010_1_0000;
   localparam logic [IW-1:0] I_IN0    = 9'b0010_0_0000;
   localparam logic [IW-1:0] I_HALT   = 9'b1101_0_0000;

   // Directed scenarios with literal expectations, then randomized traffic.
   initial begin
      rst_n = 1'b1; instr = '0; instr_valid = 1'b0; in_valid = 1'b0; alu_c = 1'b0; alu_z = 1'b0;
      #1 rst_n = 1'b0;

      for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("lit_rst_instr_ready", instr_ready, 1'b0);
      checkOutput("lit_rst_ld_n", ld_n, 4'b1111);
      checkOutput("lit_rst_sel", sel, 2'b11);

      // MOV r1,#5
      applyStimulus(1'b1, I_MOV1_5, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("lit_release_instr_ready", instr_ready, 1'b1);
      applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("lit_mov_ld_n", ld_n, 4'b1101);
      checkOutput("lit_mov_sel", sel, 2'b11);
      checkOutput("lit_mov_imm", imm, 4'b0101);
      checkOutput("lit_mov_busy", instr_ready, 1'b0);
      applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("lit_mov_ready_again", instr_ready, 1'b1);

      // ADD r0,#F with carry, then JNC must not branch
      applyStimulus(1'b1, I_ADD0_F, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("lit_add_ld_n", ld_n, 4'b1110);
      checkOutput("lit_add_sel", sel, 2'b00);
      checkOutput("lit_add_src", src_reg, 1'b0);
      applyStimulus(1'b1, I_JNC_3, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("lit_add_cflag", c_flag, 1'b1);
      applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("lit_jnc_taken_not", ld_n, 4'b1111);

      // ADD with zero result, JZ taken (adder noise must not touch flags), JNC taken
      applyStimulus(1'b1, I_ADD0_F, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, I_JZ_A, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("lit_add_zflag", z_flag, 1'b1);
      applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("lit_jz_ld_n", ld_n, 4'b0111);
      checkOutput("lit_jz_imm", imm, 4'b1010);
      applyStimulus(1'b1, I_JNC_2, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("lit_jnc_ld_n", ld_n, 4'b0111);

      // IN r1 stalls three cycles, loads only when data arrives
      applyStimulus(1'b1, I_IN1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
         checkOutput("lit_in_wait_ready", in_ready, 1'b1);
         checkOutput("lit_in_wait_ld_n", ld_n, 4'b1111);
      end
      applyStimulus(1'b1, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("lit_in_load_ld_n", ld_n, 4'b1101);
      checkOutput("lit_in_load_sel", sel, 2'b10);
      applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("lit_in_done_ld_n", ld_n, 4'b1111);
      checkOutput("lit_in_done_in_ready", in_ready, 1'b0);

      // Set both flags, HALT, hammer instr_valid, then reset out of it
      applyStimulus(1'b1, I_ADD1_1, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, I_HALT, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, IW'($urandom), 1'b1, 1'b1, 1'b1, 1'b1);
         checkOutput("lit_halt_halted", halted, 1'b1);
         checkOutput("lit_halt_instr_ready", instr_ready, 1'b0);
         checkOutput("lit_halt_ld_n", ld_n, 4'b1111);
      end
      checkOutput("lit_halt_cflag_kept", c_flag, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("lit_halt_rst_cflag", c_flag, 1'b0);
      checkOutput("lit_halt_rst_zflag", z_flag, 1'b0);
      checkOutput("lit_halt_rst_halted", halted, 1'b0);
      applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("lit_halt_rst_ready", instr_ready, 1'b1);

      // Reset while stalled on IN, with data arriving in the same cycle
      applyStimulus(1'b1, I_IN0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
      checkOutput("lit_wait_rst_ld_n", ld_n, 4'b1111);
      checkOutput("lit_wait_rst_in_ready", in_ready, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("lit_wait_rst_fetch", instr_ready, 1'b1);

      // Randomized traffic with periodic resets to escape HALT
      for (int n = 0; n < 800; n++) begin
         applyStimulus((n % 60) != 59, IW'($urandom), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/td4x_ctrl.md
TD4X_CTRL -- requirements
Module: td4x_ctrl

Interface
REQ-001 DW, 4, data/immediate width in bits, SHALL be >=4.
REQ-002 NREG, 2, number of general registers, SHALL be 2..16; RW = max(1,clog2(NREG)).
REQ-003 clk  input  1  single clock, all state rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 instr  input  4+RW+DW  instruction {op[3:0], rd[RW-1:0], imm[DW-1:0]}.
REQ-006 instr_valid  input  1  instr is valid this cycle.
REQ-007 instr_ready  output  1  controller accepts instr this cycle.
REQ-008 alu_c  input  1  adder carry-out for current datapath operation.
REQ-009 alu_z  input  1  adder result is zero.
REQ-010 in_valid  input  1  input-port data is valid.
REQ-011 in_ready  output  1  controller consumes input-port data this cycle.
REQ-012 sel  output  2  source select: 00 register, 01 reserved, 10 input port, 11 zero.
REQ-013 src_reg  output  RW  register index read when sel=00.
REQ-014 imm  output  DW  immediate to adder, equals IR imm field.
REQ-015 ld_n  output  NREG+2  active-low loads: [NREG-1:0] registers, [NREG] output port, [NREG+1] PC.
REQ-016 c_flag, z_flag  output  1 each  registered carry and zero flags.
REQ-017 halted  output  1  controller in HALT state.

Function
REQ-018 FSM states SHALL be FETCH, EXEC, WAIT_IN, HALT.
REQ-019 FETCH: instr_ready=1; on instr_valid, IR<=instr and next state EXEC; otherwise stay.
REQ-020 EXEC SHALL last one cycle and drive ld_n/sel/src_reg per REQ-021, then return to FETCH (except REQ-023, REQ-024).
REQ-021 Decode (rd=IR rd, rs=IR imm[RW-1:0]): 0000 ADD rd,imm: sel=00,src=rd,load rd | 0011 MOV rd,imm: sel=11,load rd | 0001 MOV rd,rs: sel=00,src=rs,load rd | 0010 IN rd: sel=10,load rd | 1011 OUT imm: sel=11,load out | 1001 OUT rd: sel=00,src=rd,load out | 1111 JMP: sel=11,load PC | 1110 JNC: load PC iff c_flag=0 | 1100 JZ: load PC iff z_flag=1 | 1101 HALT | others NOP.
REQ-022 Exactly one ld_n bit SHALL be low in a load cycle; all ld_n high otherwise; outside EXEC/WAIT_IN sel=11, src_reg=0.
REQ-023 IN in EXEC with in_valid=1: in_ready=1, load rd, go FETCH; with in_valid=0: no load, go WAIT_IN.
REQ-024 WAIT_IN: sel=10, in_ready=1; ld_n[rd] low only in the cycle in_valid=1, then FETCH.
REQ-025 HALT opcode: EXEC -> HALT, no load; HALT holds until reset, instr_ready=0, halted=1, instr_valid ignored.
REQ-026 c_flag<=alu_c, z_flag<=alu_z on the clock edge ending each register-load cycle (ADD, MOV, IN); all other instructions SHALL leave flags unchanged.
REQ-027 JNC/JZ SHALL test flags as registered before the branch instruction's EXEC cycle.
REQ-028 Latency: instr accepted at edge N -> load pulse cycle N+1 -> instr_ready high again cycle N+2 (non-IN).
REQ-029 in_ready SHALL be 0 in FETCH, HALT and all EXEC cycles not executing IN.
REQ-030 NOP/reserved opcodes SHALL consume one EXEC cycle with no load and no flag change.

Reset
REQ-031 rst_n low in any state SHALL immediately force FETCH, IR=0, c_flag=0, z_flag=0, ld_n all ones, sel=11, src_reg=0, in_ready=0, halted=0.
REQ-032 instr_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after release.
REQ-033 Reset during WAIT_IN or EXEC SHALL suppress any pending load.

Structure
REQ-034 Shared package td4x_pkg SHALL hold opcode enum, sel encoding, FSM state enum, ld_n index constants (as functions of NREG).
REQ-035 Combinational opcode/flag-to-load/select mapping SHALL be sub-module td4x_op_decode; FSM, IR and flags reside in td4x_ctrl.

Verification (DW=4, NREG=2)
REQ-036 Reset then MOV r1,#5 (instr=0011_1_0101) -> next cycle ld_n=1101, sel=11, imm=0101; instr_ready=1 two cycles after accept.
REQ-037 ADD r0,#F with alu_c=1, alu_z=0 -> ld_n=1110, sel=00, src_reg=0; c_flag=1 next cycle; following JNC #3 -> ld_n all ones.
REQ-038 ADD with alu_c=0, alu_z=1 then JZ #A -> ld_n=0111, imm=1010; then JNC #2 -> ld_n=0111.
REQ-039 IN r1 with in_valid=0 for 3 cycles then 1 -> in_ready=1 throughout WAIT_IN, single ld_n=1101 pulse in the in_valid cycle only.
REQ-040 HALT then instr_valid=1 for 10 cycles -> halted=1, instr_ready=0, ld_n=1111; rst_n pulse -> FETCH, flags 0.
REQ-041 rst_n low during WAIT_IN with in_valid rising same cycle -> no load, state FETCH after release.
